// File: rtl/ecc_pkg.sv
// Shared sizing, codeword position mapping and flag type for the SECDED pipeline.
// Define ECC_SECDED_DED_EN to add the overall-parity bit and double-error detection.
package ecc_pkg;

  typedef struct packed {
    logic sbe;
    logic dbe;
  } ecc_flags_t;

  function automatic int calc_p(input int data_w);
    int p;
    p = 0;
    for (int k = 7; k >= 1; k--) begin
      if ((1 << k) >= data_w + k + 1) p = k;
    end
    return p;
  endfunction

  function automatic int calc_chk_w(input int data_w);
`ifdef ECC_SECDED_DED_EN
    return calc_p(data_w) + 1;
`else
    return calc_p(data_w);
`endif
  endfunction

  // Codeword position -> data bit index; -1 for check-bit positions (powers of two).
  function automatic int pos_to_idx(input int pos);
    int n_chk;
    int idx;
    n_chk = 0;
    idx   = -1;
    for (int k = 0; k < 8; k++) begin
      if ((1 << k) <= pos) n_chk++;
    end
    if (pos >= 3 && (pos & (pos - 1)) != 0) idx = pos - n_chk - 1;
    return idx;
  endfunction

  function automatic int idx_to_pos(input int idx);
    int pos;
    pos = 0;
    for (int p = 1; p < 128; p++) begin
      if (pos == 0 && pos_to_idx(p) == idx) pos = p;
    end
    return pos;
  endfunction

endpackage

// File: rtl/ecc_hamming_syn.sv
// Combinational Hamming syndrome (recomputed checks XOR received) and, when
// ECC_SECDED_DED_EN is defined, parity over data plus received Hamming bits.
module ecc_hamming_syn
  import ecc_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int P      = calc_p(DATA_W)
) (
  input  logic [DATA_W-1:0] i_data,
  input  logic [P-1:0]      i_ham,
`ifdef ECC_SECDED_DED_EN
  output logic              o_par,
`endif
  output logic [P-1:0]      o_syn
);

  logic [P-1:0] w_chk;

  for (genvar gi = 0; gi < P; gi++) begin : g_chk
    logic [DATA_W-1:0] w_mask;
    for (genvar gd = 0; gd < DATA_W; gd++) begin : g_mask
      localparam int POS = idx_to_pos(gd);
      assign w_mask[gd] = POS[gi];
    end
    assign w_chk[gi] = ^(i_data & w_mask);
  end

  assign o_syn = w_chk ^ i_ham;

`ifdef ECC_SECDED_DED_EN
  assign o_par = (^i_data) ^ (^i_ham);
`endif

endmodule

// File: rtl/ecc_secded_pipe.sv
// Two-stage SECDED decoder with valid/ready flow control and saturating error counters.
// ECC_SECDED_DED_EN builds the overall-parity bit, DED classification and dbe_cnt.
module ecc_secded_pipe
  import ecc_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int CNT_W  = 16,
  localparam int P      = calc_p(DATA_W),
  localparam int CHK_W  = calc_chk_w(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CHK_W-1:0]  in_chk,
  input  logic              in_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [P-1:0]      out_syn,
  output logic              out_sbe,
  output logic              out_dbe,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  sbe_cnt,
  output logic [CNT_W-1:0]  dbe_cnt
);

  logic [P-1:0]      w_syn;
  logic              w_s1_adv, w_s2_adv, w_out_xfer;
  logic              r_s1_valid, r_s1_en;
  logic [DATA_W-1:0] r_s1_data;
  logic [P-1:0]      r_s1_syn;
  logic              r_s2_valid;
  logic [DATA_W-1:0] r_s2_data;
  logic [P-1:0]      r_s2_syn;
  ecc_flags_t        r_s2_flags;
  logic [DATA_W-1:0] w_flip, w_corr;
  ecc_flags_t        w_flags;
  logic [CNT_W-1:0]  r_sbe_cnt;
`ifdef ECC_SECDED_DED_EN
  logic              w_par, w_pm, r_s1_pm;
  logic [CNT_W-1:0]  r_dbe_cnt;
`endif

  assign w_s2_adv   = !r_s2_valid || out_ready;
  assign w_s1_adv   = !r_s1_valid || w_s2_adv;
  assign in_ready   = w_s1_adv;
  assign w_out_xfer = r_s2_valid && out_ready;

  ecc_hamming_syn #(.DATA_W(DATA_W)) u_syn (
    .i_data (in_data),
    .i_ham  (in_chk[P-1:0]),
`ifdef ECC_SECDED_DED_EN
    .o_par  (w_par),
`endif
    .o_syn  (w_syn)
  );

`ifdef ECC_SECDED_DED_EN
  assign w_pm = w_par ^ in_chk[P];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_en    <= 1'b0;
      r_s1_data  <= '0;
      r_s1_syn   <= '0;
`ifdef ECC_SECDED_DED_EN
      r_s1_pm    <= 1'b0;
`endif
    end else if (w_s1_adv) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_en   <= in_en;
        r_s1_data <= in_data;
        r_s1_syn  <= w_syn;
`ifdef ECC_SECDED_DED_EN
        r_s1_pm   <= w_pm;
`endif
      end
    end
  end

  // One-hot flip mask: only a syndrome naming a data position selects a bit.
  for (genvar gi = 1; gi <= DATA_W + P; gi++) begin : g_flip
    localparam int IDX = pos_to_idx(gi);
    if (IDX >= 0) begin : g_data
      assign w_flip[IDX] = (r_s1_syn == P'(gi));
    end
  end

  always_comb begin
    w_flags = '0;
    w_corr  = r_s1_data;
    if (r_s1_en) begin
`ifdef ECC_SECDED_DED_EN
      if (r_s1_pm) begin
        if (r_s1_syn > P'(DATA_W + P)) begin
          w_flags.dbe = 1'b1;
        end else begin
          w_flags.sbe = 1'b1;
          w_corr      = r_s1_data ^ w_flip;
        end
      end else if (r_s1_syn != '0) begin
        w_flags.dbe = 1'b1;
      end
`else
      if (r_s1_syn != '0) begin
        w_flags.sbe = 1'b1;
        w_corr      = r_s1_data ^ w_flip;
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_s2_data  <= '0;
      r_s2_syn   <= '0;
      r_s2_flags <= '0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_data  <= w_corr;
        r_s2_syn   <= r_s1_syn;
        r_s2_flags <= w_flags;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sbe_cnt <= '0;
    end else if (cnt_clr) begin
      r_sbe_cnt <= '0;
    end else if (w_out_xfer && r_s2_flags.sbe && r_sbe_cnt != '1) begin
      r_sbe_cnt <= r_sbe_cnt + CNT_W'(1);
    end
  end

`ifdef ECC_SECDED_DED_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dbe_cnt <= '0;
    end else if (cnt_clr) begin
      r_dbe_cnt <= '0;
    end else if (w_out_xfer && r_s2_flags.dbe && r_dbe_cnt != '1) begin
      r_dbe_cnt <= r_dbe_cnt + CNT_W'(1);
    end
  end
  assign dbe_cnt = r_dbe_cnt;
`else
  assign dbe_cnt = '0;
`endif

  assign out_valid = r_s2_valid;
  assign out_data  = r_s2_data;
  assign out_syn   = r_s2_syn;
  assign out_sbe   = r_s2_flags.sbe;
  assign out_dbe   = r_s2_flags.dbe;
  assign sbe_cnt   = r_sbe_cnt;

endmodule

// File: tb/tb_ecc_secded_pipe.sv
// Randomized and directed bench for ecc_secded_pipe against a codeword-level model;
// follows ECC_SECDED_DED_EN the same way the design does.
module tb_ecc_secded_pipe;

  localparam int DW = 32;
  localparam int P  = 6;
  localparam int N  = DW + P;
  localparam int CW = 16;
`ifdef ECC_SECDED_DED_EN
  localparam int CHK_W = P + 1;
  localparam bit DED   = 1'b1;
`else
  localparam int CHK_W = P;
  localparam bit DED   = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst, in_valid, in_ready, in_en;
  logic             out_valid, out_ready, out_sbe, out_dbe, cnt_clr;
  logic [DW-1:0]    in_data, out_data;
  logic [CHK_W-1:0] in_chk;
  logic [P-1:0]     out_syn;
  logic [CW-1:0]    sbe_cnt, dbe_cnt;

  always #5 clk = ~clk;

  ecc_secded_pipe #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_chk    (in_chk),
    .in_en     (in_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_syn   (out_syn),
    .out_sbe   (out_sbe),
    .out_dbe   (out_dbe),
    .cnt_clr   (cnt_clr),
    .sbe_cnt   (sbe_cnt),
    .dbe_cnt   (dbe_cnt)
  );

  typedef struct packed {
    logic [DW-1:0] d;
    logic [P-1:0]  syn;
    logic          sbe;
    logic          dbe;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   m_sbe   = 0;
  int   m_dbe   = 0;
  bit   bulk    = 1'b0;
  int   rdy_mode = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: lay out the received codeword, syndrome = XOR of positions of set bits.
  function automatic exp_t model(input logic [DW-1:0] d, input logic [CHK_W-1:0] c, input logic en);
    exp_t e;
    int   syn, par, di, pm;
    int   idx_at[64];
    logic b;
    syn = 0; par = 0; di = 0; pm = 0;
    for (int i = 0; i < 64; i++) idx_at[i] = -1;
    for (int pos = 1; pos <= N; pos++) begin
      if ((pos & (pos - 1)) == 0) begin
        b = c[$clog2(pos)];
      end else begin
        b = d[di];
        idx_at[pos] = di;
        di++;
      end
      if (b) begin
        syn ^= pos;
        par ^= 1;
      end
    end
`ifdef ECC_SECDED_DED_EN
    pm = par ^ int'(c[P]);
`endif
    e.d = d; e.syn = P'(syn); e.sbe = 1'b0; e.dbe = 1'b0;
    if (en) begin
      bit fix;
      fix = 1'b0;
      if (DED) begin
        if (pm != 0) begin
          if (syn > N) e.dbe = 1'b1;
          else begin e.sbe = 1'b1; fix = 1'b1; end
        end else if (syn != 0) begin
          e.dbe = 1'b1;
        end
      end else if (syn != 0) begin
        e.sbe = 1'b1;
        fix = 1'b1;
      end
      if (fix && syn <= N && idx_at[syn] >= 0) e.d[idx_at[syn]] = ~e.d[idx_at[syn]];
    end
    return e;
  endfunction

  function automatic logic [CHK_W-1:0] encode(input logic [DW-1:0] d);
    logic [CHK_W-1:0] c;
    int di, par;
    c = '0; di = 0; par = 0;
    for (int pos = 1; pos <= N; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        if (d[di]) begin
          for (int k = 0; k < P; k++) if (pos[k]) c[k] = ~c[k];
          par ^= 1;
        end
        di++;
      end
    end
    for (int k = 0; k < P; k++) par ^= int'(c[k]);
`ifdef ECC_SECDED_DED_EN
    c[P] = par[0];
`endif
    return c;
  endfunction

  // Monitor: output head must match the model while valid; pop on transfer.
  initial begin
    bit   stall_prev;
    exp_t e;
    stall_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_prev = 1'b0;
        continue;
      end
      if (stall_prev) check_eq("hold_valid", out_valid, 1);
      if (!bulk) begin
        check_eq("sbe_cnt", sbe_cnt, m_sbe);
        check_eq("dbe_cnt", dbe_cnt, m_dbe);
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check_eq("spurious_out", out_valid, 0);
        end else begin
          e = exp_q[0];
          if (!bulk) begin
            check_eq("out_data", out_data, e.d);
            check_eq("out_syn", out_syn, e.syn);
            check_eq("out_flags", {out_sbe, out_dbe}, {e.sbe, e.dbe});
          end
          if (out_ready) begin
            void'(exp_q.pop_front());
            if (!bulk)
              $display("[TB] out data=%08h syn=%0d sbe=%0d dbe=%0d", out_data, out_syn, out_sbe, out_dbe);
          end
        end
      end
      if (cnt_clr) begin
        m_sbe = 0;
        m_dbe = 0;
      end else if (out_valid && out_ready && exp_q.size() >= 0) begin
        if (e.sbe && m_sbe < 65535) m_sbe++;
        if (e.dbe && m_dbe < 65535) m_dbe++;
      end
      if (in_valid && in_ready) exp_q.push_back(model(in_data, in_chk, in_en));
      stall_prev = out_valid && !out_ready;
      e = '0;
    end
  end

  initial begin
    int phase;
    phase = 0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1: begin
          out_ready = (phase == 0 || phase == 3);
          phase = (phase + 1) % 4;
        end
        2: out_ready = ($urandom_range(0, 2) != 0);
        default: out_ready = 1'b1;
      endcase
    end
  end

  task automatic send(input logic [DW-1:0] d, input logic [CHK_W-1:0] c, input logic en);
    bit acc;
    acc = 1'b0;
    in_valid = 1'b1; in_data = d; in_chk = c; in_en = en;
    for (int n = 0; n < 200 && !acc; n++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) check_eq("send_accept", acc, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 500) check_eq("drain", exp_q.size(), 0);
  endtask

  task automatic directed(input string tag, input logic [DW-1:0] d, input logic [CHK_W-1:0] c,
                          input logic en, input logic [DW-1:0] xd, input logic [P-1:0] xs,
                          input logic xsbe, input logic xdbe);
    send(d, c, en);
    check_eq({tag, "_lat1"}, out_valid, 0);
    @(posedge clk);
    #1;
    check_eq({tag, "_valid"}, out_valid, 1);
    check_eq({tag, "_data"}, out_data, xd);
    check_eq({tag, "_syn"}, out_syn, xs);
    check_eq({tag, "_sbe"}, out_sbe, xsbe);
    check_eq({tag, "_dbe"}, out_dbe, xdbe);
    drain();
  endtask

  task automatic rand_word(output logic [DW-1:0] d, output logic [CHK_W-1:0] c);
    logic [DW+CHK_W-1:0] cw;
    int b;
    d = $urandom;
    c = encode(d);
    if ($urandom_range(0, 9) == 0) begin
      c = CHK_W'($urandom);
    end else begin
      cw = {c, d};
      for (int k = $urandom_range(0, 3); k > 0; k--) begin
        b = $urandom_range(0, DW + CHK_W - 1);
        cw[b] = ~cw[b];
      end
      {c, d} = cw;
    end
  endtask

  initial begin
    logic [CHK_W-1:0] c_ones;
    logic [DW-1:0]    d;
    logic [CHK_W-1:0] c;
    exp_t             e;
    c_ones = '1;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_chk = '0; in_en = 1'b0;
    out_ready = 1'b1; cnt_clr = 1'b0;
    #2;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_out_syn", {out_syn, out_sbe, out_dbe}, 0);
    check_eq("rst_cnts", {sbe_cnt, dbe_cnt}, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    directed("clean", 32'h0, CHK_W'(0), 1'b1, 32'h0, P'(0), 1'b0, 1'b0);
    directed("sbe_d0", 32'h1, CHK_W'(0), 1'b1, 32'h0, P'(3), 1'b1, 1'b0);
    directed("dbe_d01", 32'h3, CHK_W'(0), 1'b1, DED ? 32'h3 : 32'h7, P'(6), !DED, DED);
    directed("sbe_chk0", 32'h0, CHK_W'(1), 1'b1, 32'h0, P'(1), 1'b1, 1'b0);
    directed("en_off", 32'h0, CHK_W'(1), 1'b0, 32'h0, P'(1), 1'b0, 1'b0);
    check_eq("en_off_cnt", sbe_cnt, DED ? 2 : 3);
    directed("syn_oor", 32'h0, c_ones, 1'b1, 32'h0, P'(63), !DED, DED);
    directed("sbe_d31", 32'h8000_0000, CHK_W'(0), 1'b1, 32'h0, P'(38), 1'b1, 1'b0);
    check_eq("dir_sbe_cnt", sbe_cnt, DED ? 3 : 5);
    check_eq("dir_dbe_cnt", dbe_cnt, DED ? 2 : 0);

    rdy_mode = 2;
    for (int i = 0; i < 300; i++) begin
      rand_word(d, c);
      send(d, c, ($urandom_range(0, 9) != 0));
    end
    drain();

    rdy_mode = 1;
    for (int i = 0; i < 10; i++) begin
      rand_word(d, c);
      send(d, c, 1'b1);
    end
    drain();

    rdy_mode = 0;
    @(posedge clk);
    #1;
    in_valid = 1'b1; in_data = 32'h1; in_chk = '0; in_en = 1'b1;
    @(posedge clk);
    #1;
    in_data = 32'h3;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    exp_q.delete();
    m_sbe = 0;
    m_dbe = 0;
    #1;
    check_eq("midrst_out_valid", out_valid, 0);
    check_eq("midrst_out_data", out_data, 0);
    check_eq("midrst_cnts", {sbe_cnt, dbe_cnt}, 0);
    check_eq("midrst_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    d = 32'h0000_0400;
    c = encode(32'h0000_0000);
    e = model(d, c, 1'b1);
    directed("post_rst", d, c, 1'b1, e.d, e.syn, e.sbe, e.dbe);

    cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
    bulk = 1'b1;
    for (int i = 0; i < 65535; i++) send(32'h1, CHK_W'(0), 1'b1);
    drain();
    bulk = 1'b0;
    check_eq("sat_fill", sbe_cnt, 16'hFFFF);
    directed("sat_more", 32'h1, CHK_W'(0), 1'b1, 32'h0, P'(3), 1'b1, 1'b0);
    check_eq("sat_hold", sbe_cnt, 16'hFFFF);

    send(32'h1, CHK_W'(0), 1'b1);
    @(posedge clk);
    #1;
    check_eq("clr_race_valid", out_valid, 1);
    cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
    check_eq("clr_wins", sbe_cnt, 0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ecc_secded_pipe.md
ECC_SECDED_PIPE -- requirements
Module: ecc_secded_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data word width, legal 8/16/32/64.
REQ-002 SHALL have parameter CNT_W, default 16, error-counter width.
REQ-003 SHALL derive P = smallest integer with 2^P >= DATA_W+P+1 (6 for DATA_W=32), and CHK_W = P+1 with ECC_SECDED_DED_EN defined, else P.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 in_valid  input  1  input word valid.
REQ-007 in_ready  output  1  decoder accepts input this cycle.
REQ-008 in_data  input  DATA_W  received data.
REQ-009 in_chk  input  CHK_W  received check bits; [P-1:0] Hamming, [P] overall parity when DED built.
REQ-010 in_en  input  1  correction enable, sampled with the word.
REQ-011 out_valid  output  1  output word valid.
REQ-012 out_ready  input  1  downstream accepts output.
REQ-013 out_data  output  DATA_W  corrected data.
REQ-014 out_syn  output  P  Hamming syndrome of the word.
REQ-015 out_sbe / out_dbe  output  1 each  single-bit corrected / uncorrectable error.
REQ-016 cnt_clr  input  1  synchronous clear of both counters.
REQ-017 sbe_cnt / dbe_cnt  output  CNT_W each  saturating error counts.

Function
REQ-018 Code SHALL be Hamming: codeword positions 1..DATA_W+P; check bit i at position 2^i; data bits fill remaining positions ascending (data[0] at 3, data[1] at 5, data[2] at 6, data[3] at 7).
REQ-019 Check bit i SHALL be XOR of data bits whose position has bit i set; out_syn SHALL be recomputed XOR received Hamming bits.
REQ-020 Overall parity (DED build) SHALL be XOR of all data and P Hamming bits; mismatch flag pm = recomputed XOR in_chk[P].
REQ-021 DED build: syn=0,pm=0 clean; pm=1 with syn a data position -> flip that bit, sbe; pm=1 with syn 0 or a check position -> data unchanged, sbe; pm=1 with syn > DATA_W+P -> unchanged, dbe; pm=0,syn!=0 -> unchanged, dbe.
REQ-022 Non-DED build: syn!=0 within range -> correct as REQ-021, sbe; syn out of range -> unchanged, sbe; out_dbe SHALL be constant 0.
REQ-023 in_en=0 SHALL pass in_data unchanged with sbe=dbe=0, out_syn still reported, no counting.
REQ-024 Pipeline SHALL be two registered stages (S1 syndrome/parity, S2 correction/flags); latency exactly 2 cycles with out_ready held high; throughput 1 word/cycle.
REQ-025 Transfer SHALL occur when valid&&ready; stage advances when its successor is empty or transferring; in_ready SHALL be combinational on out_ready and stage occupancy, no word dropped or duplicated under any backpressure pattern.
REQ-026 out_valid SHALL NOT drop, nor out_* change, while out_valid=1 and out_ready=0.
REQ-027 Counters SHALL increment by 1 when a word with the flag set transfers on the output, saturating at all-ones.
REQ-028 cnt_clr SHALL win over a simultaneous increment (result 0).

Reset
REQ-029 rst SHALL asynchronously empty both stages: out_valid=0, out_data=0, out_syn=0, out_sbe=0, out_dbe=0, sbe_cnt=dbe_cnt=0; in_ready=1 during and after reset.
REQ-030 Reset mid-transfer SHALL discard all in-flight words; first post-reset output is the first word accepted after deassertion.

Configuration
REQ-031 Macro ECC_SECDED_DED_EN SHALL, when defined, build the overall-parity bit, DED classification and dbe_cnt logic; undefined, CHK_W=P, out_dbe=0, dbe_cnt=0 constant.

Structure
REQ-032 Package ecc_pkg SHALL hold the P/CHK_W computation function, position-to-data-index mapping function and flag struct type.
REQ-033 Sub-module ecc_hamming_syn (combinational, DATA_W parameter) SHALL compute check bits and overall parity; instantiated once in S1.

Verification (DATA_W=32, DED built, P=6, CHK_W=7)
REQ-034 data=0x00000000, chk=0x00 -> 2 cycles later out_data=0x00000000, syn=0, sbe=0, dbe=0.
REQ-035 data=0x00000001, chk=0x00 -> out_data=0x00000000, syn=3, sbe=1, sbe_cnt=1.
REQ-036 data=0x00000003, chk=0x00 -> out_data=0x00000003, syn=6, dbe=1, dbe_cnt=1.
REQ-037 data=0, chk=0x01 -> out_data=0, syn=1, sbe=1; same word with in_en=0 -> sbe=0, counts unchanged.
REQ-038 10 back-to-back words, out_ready toggling 1-0-0-1 -> all 10 delivered in order, held stable while stalled; rst asserted with 2 in flight -> out_valid=0 immediately, counters 0.
REQ-039 sbe_cnt preloaded to 0xFFFF by 65535 single errors -> further error keeps 0xFFFF; cnt_clr with simultaneous error -> 0.
